// File: rtl/i2s_ctrl.sv
// rtl/i2s_ctrl.sv - I2S receive master: generates SCK/WS, deserialises L/R words, delivers one sample per frame
// Sample handoff is valid/ready; an unconsumed sample is overwritten by the newest one and flagged as overrun.
module i2s_ctrl #(
  parameter int DW     = 16,
  parameter int SLOT   = 32,
  parameter int CLKDIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ws_align,
  input  logic [1:0]    chan_mode,
  input  logic          i2s_din,
  output logic          i2s_sck,
  output logic          i2s_ws,
  output logic [DW-1:0] sample_out,
  output logic          sample_valid,
  input  logic          sample_ready,
  output logic          overrun,
  input  logic          ovr_clr,
  output logic          busy
);

  localparam int DIVW = $clog2(CLKDIV);
  localparam int BCW  = $clog2(2 * SLOT);
  localparam logic [DIVW-1:0] RISE_AT = DIVW'(CLKDIV / 2 - 1);
  localparam logic [DIVW-1:0] FALL_AT = DIVW'(CLKDIV - 1);
  localparam logic [BCW-1:0]  BC_LAST = BCW'(2 * SLOT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_d;
  logic [DIVW-1:0] div_cnt;
  logic [BCW-1:0]  bit_cnt, bit_nxt;
  logic [DW-1:0]   left_sr, right_sr, sel;
  logic            rise_tick, fall_tick, frame_end, ws_nxt;
  logic            is_right, capture, ovr_set;
  logic [31:0]     bit_idx, k, off;
  logic signed [DW:0] sum;

  assign rise_tick = (state == RUN) && (div_cnt == RISE_AT);
  assign fall_tick = (state == RUN) && (div_cnt == FALL_AT);
  assign frame_end = fall_tick && (bit_cnt == BC_LAST);
  assign bit_nxt   = (bit_cnt == BC_LAST) ? '0 : bit_cnt + 1'b1;
  assign ws_nxt    = 32'(bit_nxt) >= 32'(SLOT);

  // Position within the current channel slot; I2S mode delays the MSB by one SCK.
  assign bit_idx  = 32'(bit_cnt);
  assign is_right = bit_idx >= 32'(SLOT);
  assign k        = is_right ? bit_idx - 32'(SLOT) : bit_idx;
  assign off      = ws_align ? 32'd0 : 32'd1;
  assign capture  = rise_tick && (k >= off) && (k < off + 32'(DW));

  // One extra bit of headroom makes the sum exact; dropping bit 0 is a floor divide.
  assign sum = $signed({left_sr[DW-1], left_sr}) + $signed({right_sr[DW-1], right_sr});

  always_comb begin
    sel = left_sr;
    case (chan_mode)
      2'b01:   sel = right_sr;
      2'b10:   sel = sum[DW:1];
      default: sel = left_sr;
    endcase
  end

  assign ovr_set = frame_end && sample_valid && !sample_ready;
  assign busy    = (state == RUN);

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (frame_end && !en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      i2s_sck      <= 1'b0;
      i2s_ws       <= 1'b0;
      left_sr      <= '0;
      right_sr     <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state <= state_d;
      if (state != RUN) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        i2s_sck <= 1'b0;
        i2s_ws  <= 1'b0;
      end else begin
        div_cnt <= fall_tick ? '0 : div_cnt + 1'b1;
        if (rise_tick) i2s_sck <= 1'b1;
        if (fall_tick) begin
          i2s_sck <= 1'b0;
          bit_cnt <= bit_nxt;
          i2s_ws  <= ws_nxt;
        end
      end

      if (capture) begin
        if (is_right) right_sr <= {right_sr[DW-2:0], i2s_din};
        else          left_sr  <= {left_sr[DW-2:0], i2s_din};
      end

      if (frame_end) begin
        sample_out   <= sel;
        sample_valid <= 1'b1;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end

      if (ovr_set)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_ctrl.sv
// tb/tb_i2s_ctrl.sv - directed bench for i2s_ctrl (DW=16, SLOT=32, CLKDIV=4; frame = 256 clk)
module tb_i2s_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        ws_align = 1'b0;
  logic [1:0]  chan_mode = 2'b00;
  logic        i2s_din;
  logic        i2s_sck, i2s_ws;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready = 1'b1;
  logic        overrun;
  logic        ovr_clr = 1'b0;
  logic        busy;

  int passes = 0;
  int total  = 0;
  int cyc    = 0;
  int nf     = 0;
  int base   = 0;
  logic        codec_align = 1'b0;
  logic [15:0] l_word = 16'h0;
  logic [15:0] r_word = 16'h0;
  logic        saw, hi;

  i2s_ctrl #(.DW(16), .SLOT(32), .CLKDIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .ws_align(ws_align), .chan_mode(chan_mode),
    .i2s_din(i2s_din), .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .sample_out(sample_out),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .overrun(overrun),
    .ovr_clr(ovr_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Codec model: presents the next bit after every SCK falling edge; unused slot bits are 1.
  function automatic logic frame_bit(int b, logic al, logic [15:0] l, logic [15:0] r);
    int kk;
    int o;
    logic [15:0] w;
    kk = b % 32;
    o  = al ? 0 : 1;
    w  = (b < 32) ? l : r;
    if (kk >= o && kk < o + 16) return w[15 - (kk - o)];
    return 1'b1;
  endfunction

  always @(negedge i2s_sck) nf <= nf + 1;
  assign i2s_din = frame_bit((nf - base) % 64, codec_align, l_word, r_word);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic step_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    base = nf;
    cyc  = 0;
    en   = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck", 32'(i2s_sck), 0);
    chk("rst_ws", 32'(i2s_ws), 0);
    chk("rst_sample", 32'(sample_out), 0);
    chk("rst_valid_ovr_busy", {29'd0, sample_valid, overrun, busy}, 0);
    @(negedge clk);
    rst = 1'b0;

    // I2S, left channel
    l_word = 16'h1234; r_word = 16'hABCD; codec_align = 1'b0; ws_align = 1'b0; chan_mode = 2'b00;
    start_run();
    step_to(3);
    chk("sck_rise", 32'(i2s_sck), 1);
    chk("busy_run", 32'(busy), 1);
    step_to(5);
    chk("sck_fall", 32'(i2s_sck), 0);
    step_to(128);
    chk("ws_left_end", 32'(i2s_ws), 0);
    step_to(129);
    chk("ws_right_start", 32'(i2s_ws), 1);
    step_to(256);
    chk("valid_before_end", 32'(sample_valid), 0);
    step_to(257);
    chk("i2s_left_valid", 32'(sample_valid), 1);
    chk("i2s_left_data", 32'(sample_out), 32'h1234);
    chk("ws_frame_wrap", 32'(i2s_ws), 0);
    step_to(258);
    chk("one_cycle_valid", 32'(sample_valid), 0);
    step_to(513);
    chk("i2s_left_f2", 32'(sample_out), 32'h1234);

    // Left-justified, right channel (switched on a frame boundary)
    ws_align = 1'b1; codec_align = 1'b1; chan_mode = 2'b01;
    step_to(769);
    chk("lj_right_valid", 32'(sample_valid), 1);
    chk("lj_right_data", 32'(sample_out), 32'hABCD);

    // Average
    l_word = 16'h7FFF; r_word = 16'h0001; chan_mode = 2'b10;
    step_to(1025);
    chk("avg_pos", 32'(sample_out), 32'h4000);
    l_word = 16'h8000; r_word = 16'hFFFF;
    step_to(1281);
    chk("avg_neg", 32'(sample_out), 32'hBFFF);

    // Overrun
    l_word = 16'h0001; chan_mode = 2'b00;
    step_to(1282);
    chk("avg_consumed", 32'(sample_valid), 0);
    sample_ready = 1'b0;
    step_to(1537);
    chk("ovr_first_data", 32'(sample_out), 32'h0001);
    chk("ovr_first_flag", 32'(overrun), 0);
    l_word = 16'h0002;
    step_to(1793);
    chk("ovr_latest_data", 32'(sample_out), 32'h0002);
    chk("ovr_set", 32'(overrun), 1);
    step_to(1794);
    chk("ovr_valid_held", 32'(sample_valid), 1);
    ovr_clr = 1'b1;
    step_to(1795);
    chk("ovr_cleared", 32'(overrun), 0);
    chk("ovr_data_held", 32'(sample_out), 32'h0002);
    ovr_clr = 1'b0;
    l_word = 16'h0003;
    step_to(2048);
    sample_ready = 1'b1;
    step_to(2049);
    chk("coincide_valid", 32'(sample_valid), 1);
    chk("coincide_data", 32'(sample_out), 32'h0003);
    chk("coincide_no_ovr", 32'(overrun), 0);
    l_word = 16'h5A5A;

    // Stop request at bit_cnt = 10
    step_to(2089);
    en = 1'b0;
    step_to(2304);
    chk("stop_busy_before_end", 32'(busy), 1);
    step_to(2305);
    chk("stop_sample", 32'(sample_out), 32'h5A5A);
    chk("stop_valid", 32'(sample_valid), 1);
    chk("stop_busy", 32'(busy), 0);
    hi = 1'b0;
    repeat (40) begin
      step_to(cyc + 1);
      hi = hi | i2s_sck | i2s_ws | busy;
    end
    chk("idle_lines_low", 32'(hi), 0);

    // Reset mid-frame
    l_word = 16'h0F0F;
    start_run();
    step_to(100);
    rst = 1'b1;
    #1;
    chk("midrst_sck_ws_busy", {29'd0, i2s_sck, i2s_ws, busy}, 0);
    chk("midrst_sample", 32'(sample_out), 0);
    chk("midrst_valid_ovr", {30'd0, sample_valid, overrun}, 0);
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    saw = 1'b0;
    repeat (300) begin
      @(posedge clk);
      #1;
      saw = saw | sample_valid | busy;
    end
    chk("no_sample_after_rst", 32'(saw), 0);
    start_run();
    step_to(256);
    chk("rst_full_frame_pending", 32'(sample_valid), 0);
    step_to(257);
    chk("rst_full_frame_valid", 32'(sample_valid), 1);
    chk("rst_full_frame_data", 32'(sample_out), 32'h0F0F);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
